// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, cell codes, row-mux selects
// and the drop-stage state encoding.
package connect4_pkg;

  // Board geometry: row 0 is the bottom row, column c lives in bits [2c+1:2c].
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int CELL_W = 2;
  localparam int ROW_W  = COLS * CELL_W;
  localparam int ROW_AW = 3;
  localparam int COL_AW = 3;

  // Cell codes stored in the board.
  localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
  localparam logic [CELL_W-1:0] CELL_P1    = 2'b01;
  localparam logic [CELL_W-1:0] CELL_P2    = 2'b10;

  // One-hot owners of the board row address mux.
  localparam logic [2:0] ROW_SEL_DISP  = 3'b001;
  localparam logic [2:0] ROW_SEL_PUT   = 3'b010;
  localparam logic [2:0] ROW_SEL_CHECK = 3'b100;

  // Drop-stage FSM states, with fixed encodings so older tooling sees the
  // same values it always did.
  typedef enum logic [2:0] {
    DROP_IDLE   = 3'd0,
    DROP_SCAN   = 3'd1,
    DROP_WRITE  = 3'd2,
    DROP_DONE   = 3'd3,
    DROP_REJECT = 3'd4
  } drop_state_t;

  // Only the two player codes may ever be written into the board.
  function automatic logic is_legal_player(input logic [CELL_W-1:0] p);
    return (p == CELL_P1) || (p == CELL_P2);
  endfunction

endpackage

// File: rtl/board_cell_sel.sv
// Picks one 2-bit cell out of a board row word. Purely combinational so the
// win-check stage can reuse it alongside the drop stage.
module board_cell_sel
  import connect4_pkg::*;
(
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_AW-1:0] i_col,
  output logic [CELL_W-1:0] o_cell
);

  // Cell select index is simply col*2; 4 bits cover columns 0..7 with no overflow.
  logic [COL_AW:0] w_idx;

  assign w_idx  = {i_col, 1'b0};
  assign o_cell = i_row[w_idx +: CELL_W];

endmodule

// File: rtl/chip_drop_ctrl.sv
// Gravity/placement stage: scans a column bottom-up through the board's put
// read port, writes the player's code into the lowest empty cell and reports
// the landing row, or rejects a full column / illegal player code.
module chip_drop_ctrl
  import connect4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drop_req,
  input  logic [COL_AW-1:0] drop_col,
  input  logic [CELL_W-1:0] drop_player,
  input  logic [ROW_W-1:0]  board_data,
  output logic [ROW_AW-1:0] put_chip_addr,
  output logic [COL_AW-1:0] col_addr,
  output logic [CELL_W-1:0] put_chip_data,
  output logic              put_r_en,
  output logic              put_sel,
  output logic              ram_w_en,
  output logic              drop_busy,
  output logic              drop_done,
  output logic              drop_ok,
  output logic [ROW_AW-1:0] drop_row
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  drop_state_t       r_state;
  logic [ROW_AW-1:0] r_scan_row;
  logic [COL_AW-1:0] r_col;
  logic [CELL_W-1:0] r_player;
  logic [ROW_AW-1:0] r_drop_row;

  logic [CELL_W-1:0] w_cell;
  logic              w_cell_empty;
  logic              w_on_board;

  // Cell of the latched column in the row currently presented by the board.
  board_cell_sel u_cell_sel (
    .i_row  (board_data),
    .i_col  (r_col),
    .o_cell (w_cell)
  );

  assign w_cell_empty = (w_cell == CELL_EMPTY);

  // Drop sequencing: accept, scan upward, write once, report; requests outside IDLE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DROP_IDLE;
      r_scan_row <= '0;
      r_col      <= '0;
      r_player   <= '0;
      r_drop_row <= '0;
    end else begin
      case (r_state)
        DROP_IDLE: begin
          if (drop_req) begin
            r_col      <= drop_col;
            r_player   <= drop_player;
            r_scan_row <= '0;
            r_state    <= is_legal_player(drop_player) ? DROP_SCAN : DROP_REJECT;
          end
        end
        DROP_SCAN: begin
          if (w_cell_empty) begin
            r_state <= DROP_WRITE;
          end else if (r_scan_row == LAST_ROW) begin
            r_state <= DROP_REJECT;
          end else begin
            r_scan_row <= r_scan_row + 1'b1;
          end
        end
        DROP_WRITE: begin
          r_drop_row <= r_scan_row;
          r_state    <= DROP_DONE;
        end
        DROP_DONE:   r_state <= DROP_IDLE;
        DROP_REJECT: r_state <= DROP_IDLE;
        default:     r_state <= DROP_IDLE;
      endcase
    end
  end

  // Moore outputs: the board port is only claimed while scanning or writing,
  // and the write strobe is a subset of that window.
  assign w_on_board    = (r_state == DROP_SCAN) || (r_state == DROP_WRITE);
  assign put_sel       = w_on_board;
  assign put_r_en      = w_on_board;
  assign put_chip_addr = w_on_board ? r_scan_row : '0;
  assign ram_w_en      = (r_state == DROP_WRITE);
  assign col_addr      = r_col;
  assign put_chip_data = r_player;
  assign drop_busy     = (r_state != DROP_IDLE);
  assign drop_done     = (r_state == DROP_DONE) || (r_state == DROP_REJECT);
  assign drop_ok       = (r_state == DROP_DONE);
  assign drop_row      = r_drop_row;

endmodule

// File: tb/tb_chip_drop_ctrl.sv
// Randomized self-checking bench for chip_drop_ctrl. A small board memory
// stands in for game_board; expected results come from per-column chip counts.
module tb_chip_drop_ctrl;

  logic        clk;
  logic        rst_n;
  logic        drop_req;
  logic [2:0]  drop_col;
  logic [1:0]  drop_player;
  logic [15:0] board_data;
  logic [2:0]  put_chip_addr;
  logic [2:0]  col_addr;
  logic [1:0]  put_chip_data;
  logic        put_r_en;
  logic        put_sel;
  logic        ram_w_en;
  logic        drop_busy;
  logic        drop_done;
  logic        drop_ok;
  logic [2:0]  drop_row;

  chip_drop_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drop_req      (drop_req),
    .drop_col      (drop_col),
    .drop_player   (drop_player),
    .board_data    (board_data),
    .put_chip_addr (put_chip_addr),
    .col_addr      (col_addr),
    .put_chip_data (put_chip_data),
    .put_r_en      (put_r_en),
    .put_sel       (put_sel),
    .ram_w_en      (ram_w_en),
    .drop_busy     (drop_busy),
    .drop_done     (drop_done),
    .drop_ok       (drop_ok),
    .drop_row      (drop_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board stand-in: combinational read of the addressed row, write on strobe.
  logic [15:0] board_mem [8];
  assign board_data = board_mem[put_chip_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) board_mem[r] <= '0;
    end else if (ram_w_en) begin
      board_mem[put_chip_addr][2*col_addr +: 2] <= put_chip_data;
    end
  end

  // Reference model: number of chips stacked in each column.
  int height [8];
  int last_row;
  int n_checks;
  int n_pass;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 8; c++) height[c] = 0;
    last_row = 0;
  endtask

  // One drop transaction; optionally keeps drop_req high (retargeted at col 7)
  // until the completion cycle to show that busy-time requests are ignored.
  task automatic do_drop(input logic [2:0] col, input logic [1:0] pl, input bit hold_req);
    int  exp_lat, exp_row, got_lat, writes, viol;
    bit  exp_ok, got_ok;
    exp_row = 0;
    if (pl != 2'b01 && pl != 2'b10) begin
      exp_ok = 0; exp_lat = 1;
    end else if (height[col] >= 8) begin
      exp_ok = 0; exp_lat = 8 + 1;
    end else begin
      exp_ok = 1; exp_row = height[col]; exp_lat = exp_row + 3;
    end

    @(negedge clk);
    drop_col = col; drop_player = pl; drop_req = 1'b1;
    @(posedge clk); #1;
    if (hold_req) drop_col = 3'd7;
    else drop_req = 1'b0;

    got_lat = 0; got_ok = 0; writes = 0; viol = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ram_w_en) writes++;
      if (ram_w_en && !put_sel) viol++;
      if (put_sel && !drop_busy) viol++;
      if (put_sel != put_r_en) viol++;
      if (!drop_busy) viol++;
      if (drop_done) begin
        got_lat = k; got_ok = drop_ok;
        break;
      end
    end
    drop_req = 1'b0;

    chk("latency", got_lat, exp_lat);
    chk("ok", int'(got_ok), int'(exp_ok));
    chk("writes", writes, exp_ok ? 1 : 0);
    chk("strobe_rules", viol, 0);
    if (exp_ok) begin
      last_row = exp_row;
      height[col]++;
      chk("cell", int'(board_mem[exp_row][2*col +: 2]), int'(pl));
    end
    chk("row", int'(drop_row), last_row);
    $display("drop col=%0d player=%0d hold=%0d -> lat=%0d ok=%0d row=%0d",
             col, pl, hold_req, got_lat, got_ok, drop_row);

    @(negedge clk);
    chk("idle_after", int'(drop_busy), 0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; drop_req = 1'b0; drop_col = '0; drop_player = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({put_chip_addr, col_addr, put_chip_data, put_r_en, put_sel, ram_w_en,
              drop_busy, drop_done, drop_ok, drop_row}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases: empty column, partly filled column, full column,
    // illegal player, request held during a scan.
    do_drop(3'd3, 2'b01, 0);
    for (int i = 0; i < 3; i++) do_drop(3'd5, (i % 2 == 0) ? 2'b01 : 2'b10, 0);
    do_drop(3'd5, 2'b10, 0);
    for (int i = 0; i < 8; i++) do_drop(3'd0, 2'b01, 0);
    do_drop(3'd0, 2'b10, 0);
    do_drop(3'd2, 2'b11, 0);
    do_drop(3'd4, 2'b00, 0);
    do_drop(3'd1, 2'b10, 1);

    // Random drops over all columns, including overfilled ones and illegal codes.
    for (int n = 0; n < 70; n++) begin
      logic [2:0] c;
      logic [1:0] p;
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) p = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      else p = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      do_drop(c, p, ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    drop_col = 3'd5; drop_player = 2'b01; drop_req = 1'b1;
    @(posedge clk); #1;
    drop_req = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("scanning_before_reset", int'(put_sel), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({put_chip_addr, col_addr, put_chip_data, put_r_en, put_sel, ram_w_en,
              drop_busy, drop_done, drop_ok, drop_row}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_drop(3'd5, 2'b10, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
